// File: rtl/stream_source_i64.sv
// stream_source_i64: on a start handshake, emits an arithmetic sequence of
// 64-bit elements, then an end-of-stream token, then a completion token.
module stream_source_i64 #(
    parameter int unsigned LEN_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [63:0]      cfg_start,
    input  logic [63:0]      cfg_step,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             inCtrl_valid,
    output logic             inCtrl_ready,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [63:0]      out0_data_field0,
    output logic             out0_data_field1,
    output logic             outCtrl_valid,
    input  logic             outCtrl_ready
);

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StEos,
        StDone
    } state_e;

    localparam logic [LEN_W-1:0] LenOne = {{(LEN_W-1){1'b0}}, 1'b1};

    state_e            state_q;
    logic [63:0]       value_q;
    logic [63:0]       step_q;
    logic [LEN_W-1:0]  remain_q;

    // Sequencer: latches the configuration on start and walks the four phases.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            value_q  <= '0;
            step_q   <= '0;
            remain_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (inCtrl_valid) begin
                        value_q  <= cfg_start;
                        step_q   <= cfg_step;
                        remain_q <= cfg_len;
                        state_q  <= (cfg_len != '0) ? StStream : StEos;
                    end
                end
                StStream: begin
                    if (out0_ready) begin
                        value_q  <= value_q + step_q;
                        // Stops at 1, so a full-scale length never wraps the counter.
                        remain_q <= remain_q - LenOne;
                        if (remain_q == LenOne) begin
                            state_q <= StEos;
                        end
                    end
                end
                StEos: begin
                    if (out0_ready) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (outCtrl_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs decode the state register only; no ready-to-output path exists.
    always_comb begin
        inCtrl_ready     = (state_q == StIdle) && !reset;
        out0_valid       = (state_q == StStream) || (state_q == StEos);
        out0_data_field1 = (state_q == StEos);
        out0_data_field0 = (state_q == StStream) ? value_q : 64'd0;
        outCtrl_valid    = (state_q == StDone);
    end

endmodule

// File: tb/tb_stream_source_i64.sv
// Directed self-checking bench for stream_source_i64.
module tb_stream_source_i64;

    logic        clock;
    logic        reset;
    logic [63:0] cfg_start;
    logic [63:0] cfg_step;
    logic [31:0] cfg_len;
    logic        inCtrl_valid;
    logic        inCtrl_ready;
    logic        out0_valid;
    logic        out0_ready;
    logic [63:0] out0_data_field0;
    logic        out0_data_field1;
    logic        outCtrl_valid;
    logic        outCtrl_ready;

    int checks = 0;
    int errors = 0;

    logic [65:0] tok;
    assign tok = {out0_valid, out0_data_field1, out0_data_field0};

    localparam logic [65:0] EosTok  = {1'b1, 1'b1, 64'd0};
    localparam logic [65:0] NoneTok = 66'd0;

    stream_source_i64 #(.LEN_W(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .cfg_start        (cfg_start),
        .cfg_step         (cfg_step),
        .cfg_len          (cfg_len),
        .inCtrl_valid     (inCtrl_valid),
        .inCtrl_ready     (inCtrl_ready),
        .out0_valid       (out0_valid),
        .out0_ready       (out0_ready),
        .out0_data_field0 (out0_data_field0),
        .out0_data_field1 (out0_data_field1),
        .outCtrl_valid    (outCtrl_valid),
        .outCtrl_ready    (outCtrl_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a start request across one edge; returns in cycle k+1.
    task automatic do_start(input logic [63:0] s, input logic [63:0] st, input logic [31:0] len);
        cfg_start    = s;
        cfg_step     = st;
        cfg_len      = len;
        inCtrl_valid = 1'b1;
        step();
        inCtrl_valid = 1'b0;
        cfg_start    = '1;
        cfg_step     = '1;
        cfg_len      = '1;
    endtask

    task automatic test_reset();
        checks++;
        if (inCtrl_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got %b want 0", inCtrl_ready);
        end
        checks++;
        if (tok !== NoneTok) begin
            errors++; $display("FAIL reset_out0 got %h want %h", tok, NoneTok);
        end
        checks++;
        if (outCtrl_valid !== 1'b0) begin
            errors++; $display("FAIL reset_outctrl got %b want 0", outCtrl_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (inCtrl_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_in_ready got %b want 1", inCtrl_ready);
        end
        step();
    endtask

    task automatic test_basic();
        logic [63:0] vals [4];
        vals[0] = 64'd5; vals[1] = 64'd8; vals[2] = 64'd11; vals[3] = 64'd14;
        do_start(64'd5, 64'd3, 32'd4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tok !== {2'b10, vals[i]}) begin
                errors++; $display("FAIL basic_elem%0d got %h want %h", i, tok, {2'b10, vals[i]});
            end
            checks++;
            if (inCtrl_ready !== 1'b0) begin
                errors++; $display("FAIL basic_busy%0d got %b want 0", i, inCtrl_ready);
            end
            step();
        end
        checks++;
        if (tok !== EosTok) begin
            errors++; $display("FAIL basic_eos got %h want %h", tok, EosTok);
        end
        step();
        checks++;
        if ({outCtrl_valid, out0_valid} !== 2'b10) begin
            errors++; $display("FAIL basic_done got %b want 10", {outCtrl_valid, out0_valid});
        end
        step();
        checks++;
        if ({inCtrl_ready, outCtrl_valid} !== 2'b10) begin
            errors++; $display("FAIL basic_idle got %b want 10", {inCtrl_ready, outCtrl_valid});
        end
    endtask

    task automatic test_zero_len();
        do_start(64'h1234, 64'd7, 32'd0);
        checks++;
        if (tok !== EosTok) begin
            errors++; $display("FAIL zero_eos got %h want %h", tok, EosTok);
        end
        step();
        checks++;
        if ({outCtrl_valid, out0_valid} !== 2'b10) begin
            errors++; $display("FAIL zero_done got %b want 10", {outCtrl_valid, out0_valid});
        end
        step();
        checks++;
        if ({inCtrl_ready, outCtrl_valid, out0_valid} !== 3'b100) begin
            errors++; $display("FAIL zero_idle got %b want 100",
                               {inCtrl_ready, outCtrl_valid, out0_valid});
        end
    endtask

    task automatic test_backpressure();
        logic [6:0]  pat;
        logic [65:0] exp [4];
        int          idx;
        pat = 7'b1101001;  // bit c is out0_ready in cycle k+1+c: 1,0,0,1,0,1,1
        exp[0] = {2'b10, 64'd0}; exp[1] = {2'b10, 64'd1};
        exp[2] = {2'b10, 64'd2}; exp[3] = EosTok;
        idx = 0;
        do_start(64'd0, 64'd1, 32'd3);
        for (int c = 0; c < 7; c++) begin
            out0_ready = pat[c];
            checks++;
            if (tok !== exp[idx]) begin
                errors++; $display("FAIL bp_cycle%0d got %h want %h", c, tok, exp[idx]);
            end
            step();
            if (pat[c]) idx++;
        end
        out0_ready = 1'b1;
        checks++;
        if ({outCtrl_valid, out0_valid} !== 2'b10) begin
            errors++; $display("FAIL bp_done got %b want 10", {outCtrl_valid, out0_valid});
        end
        step();
        step();
    endtask

    task automatic test_wrap();
        logic [65:0] exp [4];
        exp[0] = {2'b10, 64'hFFFF_FFFF_FFFF_FFFE};
        exp[1] = {2'b10, 64'hFFFF_FFFF_FFFF_FFFF};
        exp[2] = {2'b10, 64'h0};
        exp[3] = EosTok;
        do_start(64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 32'd3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tok !== exp[i]) begin
                errors++; $display("FAIL wrap_tok%0d got %h want %h", i, tok, exp[i]);
            end
            step();
        end
        step();
    endtask

    task automatic test_stall_and_ignore();
        logic [63:0] vals [4];
        vals[0] = 64'd10; vals[1] = 64'd20; vals[2] = 64'd30; vals[3] = 64'd40;
        outCtrl_ready = 1'b0;
        do_start(64'd10, 64'd10, 32'd4);
        for (int i = 0; i < 4; i++) begin
            // Start request with different config while streaming must be ignored.
            inCtrl_valid = (i == 1);
            cfg_start    = 64'd999;
            cfg_step     = 64'd0;
            cfg_len      = 32'd0;
            checks++;
            if (tok !== {2'b10, vals[i]}) begin
                errors++; $display("FAIL ign_elem%0d got %h want %h", i, tok, {2'b10, vals[i]});
            end
            step();
        end
        inCtrl_valid = 1'b0;
        checks++;
        if (tok !== EosTok) begin
            errors++; $display("FAIL ign_eos got %h want %h", tok, EosTok);
        end
        step();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({outCtrl_valid, inCtrl_ready, out0_valid} !== 3'b100) begin
                errors++; $display("FAIL cstall%0d got %b want 100", c,
                                   {outCtrl_valid, inCtrl_ready, out0_valid});
            end
            step();
        end
        outCtrl_ready = 1'b1;
        checks++;
        if (outCtrl_valid !== 1'b1) begin
            errors++; $display("FAIL cstall_hold got %b want 1", outCtrl_valid);
        end
        step();
        checks++;
        if ({inCtrl_ready, outCtrl_valid} !== 2'b10) begin
            errors++; $display("FAIL cstall_idle got %b want 10", {inCtrl_ready, outCtrl_valid});
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [65:0] exp [3];
        exp[0] = {2'b10, 64'd100}; exp[1] = {2'b10, 64'd102}; exp[2] = EosTok;
        do_start(64'd0, 64'd1, 32'd10);
        step();
        step();
        // Two elements transferred; third element now presented.
        checks++;
        if (tok !== {2'b10, 64'd2}) begin
            errors++; $display("FAIL mid_elem2 got %h want %h", tok, {2'b10, 64'd2});
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({out0_valid, outCtrl_valid, inCtrl_ready} !== 3'b000) begin
            errors++; $display("FAIL mid_async_reset got %b want 000",
                               {out0_valid, outCtrl_valid, inCtrl_ready});
        end
        #1 reset = 1'b0;
        step();
        checks++;
        if ({inCtrl_ready, out0_valid} !== 2'b10) begin
            errors++; $display("FAIL mid_idle got %b want 10", {inCtrl_ready, out0_valid});
        end
        do_start(64'd100, 64'd2, 32'd2);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tok !== exp[i]) begin
                errors++; $display("FAIL restart_tok%0d got %h want %h", i, tok, exp[i]);
            end
            step();
        end
        checks++;
        if (outCtrl_valid !== 1'b1) begin
            errors++; $display("FAIL restart_done got %b want 1", outCtrl_valid);
        end
        step();
    endtask

    initial begin
        reset         = 1'b1;
        cfg_start     = '0;
        cfg_step      = '0;
        cfg_len       = '0;
        inCtrl_valid  = 1'b0;
        out0_ready    = 1'b1;
        outCtrl_ready = 1'b1;
        step();
        step();
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_wrap();
        test_stall_and_ignore();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
